// File: rtl/dphy_lane_deskew_ctrl.sv
// Multi-lane D-PHY deskew controller: re-arms aligners, measures lane skew, equalises lanes.
// Optional `DPHY_DESKEW_STATS_EN adds saturating lock_cnt_o / err_cnt_o event counters.
module dphy_lane_deskew_ctrl #(
    parameter int LANES        = 4,
    parameter int MAX_SKEW     = 3,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hs_data_valid_i,
    input  logic [LANES-1:0]   lane_valid_i,
    input  logic [8*LANES-1:0] lane_byte_i,
    output logic [LANES-1:0]   reset_align_o,
    output logic [8*LANES-1:0] data_o,
    output logic               valid_o,
    output logic               locked_o,
    output logic               skew_err_o,
    output logic               timeout_err_o
`ifdef DPHY_DESKEW_STATS_EN
    ,
    output logic [15:0]        lock_cnt_o,
    output logic [15:0]        err_cnt_o
`endif
);

    localparam int AW = $clog2(MAX_SKEW + 2);
    localparam int DW = (MAX_SKEW > 1) ? $clog2(MAX_SKEW + 1) : 1;
    localparam int TW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_LOCKED, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [AW-1:0]     acnt_q, acnt_d;
    logic              arun_q, arun_d;
    logic [LANES-1:0]  seen_q, seen_d;
    logic [AW-1:0]     arr_q [LANES];
    logic [AW-1:0]     arr_d [LANES];
    logic [DW-1:0]     dly_q [LANES];
    logic [DW-1:0]     dly_d [LANES];
    logic [7:0]        dl_q  [LANES][MAX_SKEW];
    logic [7:0]        tap   [LANES];
    logic              skew_d, tout_d;

    logic [AW-1:0]     cur;
    logic [LANES-1:0]  fresh;
    logic              late, all_seen, dropped;

    logic [LANES-1:0]   reset_align_q;
    logic [8*LANES-1:0] data_q;
    logic               valid_q, locked_q, skew_q, tout_q;

    // Arrival of a lane rising this cycle; 0 until the first lane has risen.
    assign cur      = arun_q ? acnt_q : '0;
    assign fresh    = lane_valid_i & ~seen_q;
    assign late     = (cur == AW'(MAX_SKEW + 1));
    assign all_seen = &(seen_q | fresh);
    assign dropped  = |(seen_q & ~lane_valid_i);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        acnt_d  = acnt_q;
        arun_d  = arun_q;
        seen_d  = seen_q;
        skew_d  = 1'b0;
        tout_d  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            arr_d[k] = arr_q[k];
            dly_d[k] = dly_q[k];
        end

        unique case (state_q)
            S_IDLE: begin
                if (hs_data_valid_i) state_d = S_ARM;
            end
            S_ARM: begin
                tcnt_d  = '0;
                acnt_d  = '0;
                arun_d  = 1'b0;
                seen_d  = '0;
                for (int k = 0; k < LANES; k++) dly_d[k] = '0;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                tcnt_d = tcnt_q + TW'(1);
                if (arun_q) begin
                    if (!late) acnt_d = acnt_q + AW'(1);
                end else if (|lane_valid_i) begin
                    arun_d = 1'b1;
                    acnt_d = AW'(1);
                end

                if (dropped || late) begin
                    state_d = S_ERROR;
                    skew_d  = 1'b1;
                end else if (all_seen) begin
                    // The lanes arriving now are the latest, so cur is the max arrival.
                    for (int k = 0; k < LANES; k++) begin
                        if (fresh[k]) arr_d[k] = cur;
                        dly_d[k] = DW'(cur - arr_d[k]);
                    end
                    seen_d  = '1;
                    state_d = S_LOCKED;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        if (fresh[k]) arr_d[k] = cur;
                    end
                    seen_d = seen_q | fresh;
                    if (tcnt_q == TW'(SYNC_TIMEOUT - 1)) begin
                        state_d = S_ERROR;
                        tout_d  = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (lane_valid_i != '1) begin
                    state_d = S_ERROR;
                    skew_d  = 1'b1;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        // End of burst wins over every other transition, and keeps the old delays.
        if (state_q != S_IDLE && !hs_data_valid_i) begin
            state_d = S_IDLE;
            skew_d  = 1'b0;
            tout_d  = 1'b0;
            for (int k = 0; k < LANES; k++) dly_d[k] = dly_q[k];
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            tap[k] = lane_byte_i[8*k +: 8];
            for (int j = 1; j <= MAX_SKEW; j++) begin
                if (dly_d[k] == DW'(j)) tap[k] = dl_q[k][j-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            tcnt_q        <= '0;
            acnt_q        <= '0;
            arun_q        <= 1'b0;
            seen_q        <= '0;
            reset_align_q <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            skew_q        <= 1'b0;
            tout_q        <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                arr_q[k] <= '0;
                dly_q[k] <= '0;
                for (int j = 0; j < MAX_SKEW; j++) dl_q[k][j] <= '0;
            end
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            acnt_q        <= acnt_d;
            arun_q        <= arun_d;
            seen_q        <= seen_d;
            reset_align_q <= (state_d == S_ARM) ? '1 : '0;
            valid_q       <= (state_d == S_LOCKED);
            locked_q      <= (state_d == S_LOCKED);
            skew_q        <= skew_d;
            tout_q        <= tout_d;
            for (int k = 0; k < LANES; k++) begin
                arr_q[k]            <= arr_d[k];
                dly_q[k]            <= dly_d[k];
                data_q[8*k +: 8]    <= tap[k];
                dl_q[k][0]          <= lane_byte_i[8*k +: 8];
                for (int j = 1; j < MAX_SKEW; j++) dl_q[k][j] <= dl_q[k][j-1];
            end
        end
    end

    assign reset_align_o = reset_align_q;
    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign locked_o      = locked_q;
    assign skew_err_o    = skew_q;
    assign timeout_err_o = tout_q;

`ifdef DPHY_DESKEW_STATS_EN
    logic [15:0] lock_cnt_q, err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (state_q == S_SYNC && state_d == S_LOCKED && lock_cnt_q != 16'hFFFF)
                lock_cnt_q <= lock_cnt_q + 16'd1;
            if (state_q != S_ERROR && state_d == S_ERROR && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign lock_cnt_o = lock_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_dphy_lane_deskew_ctrl.sv
// Directed bench for dphy_lane_deskew_ctrl with a burst-level expectation model.
module tb_dphy_lane_deskew_ctrl;

    localparam int NMAX = 100;
    localparam int BIG  = 1000;
    localparam int MS   = 3;
    localparam int TO   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_i;
    logic [3:0]  lv_i;
    logic [31:0] lb_i;
    logic [3:0]  ra_o;
    logic [31:0] data_o;
    logic        valid_o, locked_o, skew_o, to_o;
`ifdef DPHY_DESKEW_STATS_EN
    logic [15:0] lock_cnt_o, err_cnt_o;
`endif

    dphy_lane_deskew_ctrl #(.LANES(4), .MAX_SKEW(MS), .SYNC_TIMEOUT(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .hs_data_valid_i (hs_i),
        .lane_valid_i    (lv_i),
        .lane_byte_i     (lb_i),
        .reset_align_o   (ra_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .locked_o        (locked_o),
        .skew_err_o      (skew_o),
        .timeout_err_o   (to_o)
`ifdef DPHY_DESKEW_STATS_EN
        ,
        .lock_cnt_o      (lock_cnt_o),
        .err_cnt_o       (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus tables, indexed by cycle; expectations describe outputs after that cycle's edge.
    int          ncyc;
    logic        hs_v [NMAX];
    logic [3:0]  lv_v [NMAX];
    logic [31:0] by_v [NMAX];
    logic [3:0]  e_ra [NMAX];
    logic        e_val[NMAX];
    logic        e_lck[NMAX];
    logic        e_skw[NMAX];
    logic        e_to [NMAX];
    logic [31:0] e_dat[NMAX];

    int n_cmp = 0;
    int n_bad = 0;

    int sc_ra, sc_to, sc_to_at, sc_skw, sc_skw_at, sc_val, sc_first_t;
    logic [31:0] sc_first_d;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int t);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
        end
    endtask

    // Lane k rises at r_k; its j-th byte is 0x10 + k + 0x10*j. Lane dl drops at dt.
    task automatic setup(input int n, input int h, input int hf,
                         input int r0, input int r1, input int r2, input int r3,
                         input int dl, input int dt);
        int r[4];
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        ncyc = n;
        for (int t = 0; t < n; t++) begin
            hs_v[t] = (t >= h) && (t < hf);
            for (int k = 0; k < 4; k++) begin
                lv_v[t][k] = hs_v[t] && (t >= r[k]) && !(k == dl && t >= dt);
                by_v[t][8*k +: 8] = (t >= r[k]) ? 8'(16 + k + 16 * (t - r[k])) : 8'h00;
            end
        end
    endtask

    // Burst-level model: find lane first-arrival times, then decide lock/error from the rules.
    task automatic model();
        int h, the, s0, f, lk, ts, td, tt, te;
        int ft[4];
        int d[4];
        for (int t = 0; t < NMAX; t++) begin
            e_ra[t] = 4'h0; e_val[t] = 1'b0; e_lck[t] = 1'b0;
            e_skw[t] = 1'b0; e_to[t] = 1'b0; e_dat[t] = 32'h0;
        end
        h = -1;
        for (int t = 0; t < ncyc; t++) if (hs_v[t] && h < 0) h = t;
        if (h < 0) return;
        e_ra[h] = 4'hF;
        the = ncyc;
        for (int t = h + 1; t < ncyc; t++) if (!hs_v[t] && the == ncyc) the = t;
        s0 = h + 2;
        if (the < s0) return;
        f = BIG; lk = 0;
        for (int k = 0; k < 4; k++) begin
            ft[k] = BIG;
            for (int t = s0; t < the; t++) if (lv_v[t][k] && ft[k] == BIG) ft[k] = t;
            if (ft[k] < f) f = ft[k];
            if (ft[k] > lk) lk = ft[k];
        end
        ts = (f < BIG && lk > f + MS) ? f + MS + 1 : BIG;
        tt = (lk > s0 + TO - 1) ? s0 + TO - 1 : BIG;
        td = BIG;
        for (int t = s0; t < the && t <= lk && td == BIG; t++)
            for (int k = 0; k < 4; k++) if (ft[k] < t && !lv_v[t][k]) td = t;
        te = td;
        if (ts < te) te = ts;
        if (tt < te) te = tt;
        if (te < the) begin
            if (te == td || te == ts) e_skw[te] = 1'b1;
            else                      e_to[te]  = 1'b1;
            return;
        end
        if (lk >= the) return;
        for (int k = 0; k < 4; k++) d[k] = lk - ft[k];
        for (int t = lk; t < the; t++) begin
            if (t > lk && lv_v[t] != 4'hF) begin
                e_skw[t] = 1'b1;
                return;
            end
            e_val[t] = 1'b1;
            e_lck[t] = 1'b1;
            for (int k = 0; k < 4; k++) e_dat[t][8*k +: 8] = by_v[t - d[k]][8*k +: 8];
        end
    endtask

    task automatic compare_cycle(input int t);
        check("reset_align", {28'h0, ra_o}, {28'h0, e_ra[t]}, t);
        check("valid", {31'h0, valid_o}, {31'h0, e_val[t]}, t);
        check("locked", {31'h0, locked_o}, {31'h0, e_lck[t]}, t);
        check("skew_err", {31'h0, skew_o}, {31'h0, e_skw[t]}, t);
        check("timeout_err", {31'h0, to_o}, {31'h0, e_to[t]}, t);
        if (e_val[t]) check("data", data_o, e_dat[t], t);
        if (ra_o != 4'h0) sc_ra++;
        if (to_o) begin sc_to++; sc_to_at = t; end
        if (skew_o) begin sc_skw++; sc_skw_at = t; end
        if (valid_o) begin
            if (sc_val == 0) begin sc_first_t = t; sc_first_d = data_o; end
            sc_val++;
        end
    endtask

    task automatic run_scn();
        sc_ra = 0; sc_to = 0; sc_to_at = -1; sc_skw = 0; sc_skw_at = -1;
        sc_val = 0; sc_first_t = -1; sc_first_d = 32'h0;
        for (int t = 0; t < ncyc; t++) begin
            hs_i = hs_v[t];
            lv_i = lv_v[t];
            lb_i = by_v[t];
            @(posedge clk);
            @(negedge clk);
            compare_cycle(t);
        end
    endtask

    initial begin
        rst = 1'b0; hs_i = 1'b0; lv_i = 4'h0; lb_i = 32'h0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ra", {28'h0, ra_o}, 32'h0, 0);
        check("rst_data", data_o, 32'h0, 0);
        check("rst_valid", {31'h0, valid_o}, 32'h0, 0);
        check("rst_locked", {31'h0, locked_o}, 32'h0, 0);
        check("rst_skew", {31'h0, skew_o}, 32'h0, 0);
        check("rst_to", {31'h0, to_o}, 32'h0, 0);
        rst = 1'b0;

        // Aligned lanes
        setup(20, 2, 15, 5, 5, 5, 5, -1, BIG); model(); run_scn();
        check("aligned_first_t", sc_first_t, 5, 0);
        check("aligned_first_d", sc_first_d, 32'h13121110, 0);
        check("aligned_ra_cycles", sc_ra, 1, 0);

        // Skewed lanes 0,1,3,2 -> delays 3,2,0,1
        setup(20, 2, 16, 5, 6, 8, 7, -1, BIG); model(); run_scn();
        check("skewed_first_t", sc_first_t, 8, 0);
        check("skewed_first_d", sc_first_d, 32'h13121110, 0);
        check("skewed_no_err", sc_skw, 0, 0);

        // Excess skew: lane 3 four cycles late
        setup(16, 2, 12, 5, 5, 5, 9, -1, BIG); model(); run_scn();
        check("excess_skew_cnt", sc_skw, 1, 0);
        check("excess_skew_at", sc_skw_at, 9, 0);
        check("excess_no_valid", sc_val, 0, 0);

        // Timeout: no lane ever reports valid
        setup(75, 2, 70, BIG, BIG, BIG, BIG, -1, BIG); model(); run_scn();
        check("timeout_cnt", sc_to, 1, 0);
        check("timeout_at", sc_to_at, 67, 0);
        check("timeout_ra_cycles", sc_ra, 1, 0);

        // Async reset while locked, between edges
        setup(12, 2, BIG, 5, 5, 5, 5, -1, BIG); model(); run_scn();
        check("pre_rst_locked", {31'h0, locked_o}, 32'h1, 0);
        #2 rst = 1'b1; hs_i = 1'b0; lv_i = 4'h0;
        #1;
        check("arst_ra", {28'h0, ra_o}, 32'h0, 0);
        check("arst_data", data_o, 32'h0, 0);
        check("arst_valid", {31'h0, valid_o}, 32'h0, 0);
        check("arst_locked", {31'h0, locked_o}, 32'h0, 0);
        check("arst_skew", {31'h0, skew_o}, 32'h0, 0);
        check("arst_to", {31'h0, to_o}, 32'h0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ra", {28'h0, ra_o}, 32'h0, i);
            check("post_rst_locked", {31'h0, locked_o}, 32'h0, i);
        end

        // Lane 1 lost while locked, then a fresh burst relocks
        setup(16, 2, 13, 5, 5, 5, 5, 1, 10); model(); run_scn();
        check("loss_skew_at", sc_skw_at, 10, 0);
        check("loss_valid_cycles", sc_val, 5, 0);
        setup(14, 2, 12, 6, 6, 6, 6, -1, BIG); model(); run_scn();
        check("relock_first_d", sc_first_d, 32'h13121110, 0);
        check("relock_ra_cycles", sc_ra, 1, 0);
`ifdef DPHY_DESKEW_STATS_EN
        check("lock_cnt", {16'h0, lock_cnt_o}, 32'd2, 0);
        check("err_cnt", {16'h0, err_cnt_o}, 32'd1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
